// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the handshake FSM encoding, the wait-counter width and the zero word.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          WAIT_CNT_W = 4;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

endpackage

// File: rtl/dmem_if.sv
// Data-memory request/response bus between a load/store unit and the responder.
// The requester holds its request until the single-cycle dReady pulse.
interface dmem_if;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] dAddress;
    logic [31:0] dWriteData;
    logic [3:0]  dByteEn;
    logic [31:0] dReadData;
    logic        dReady;
    logic        dError;

    modport master (
        output MemRead, MemWrite, dAddress, dWriteData, dByteEn,
        input  dReadData, dReady, dError
    );

    modport slave (
        input  MemRead, MemWrite, dAddress, dWriteData, dByteEn,
        output dReadData, dReady, dError
    );

endinterface

// File: rtl/dmem_ram.sv
// Word-organised storage: byte-enabled synchronous write, combinational read.
// Contents are never reset.
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder: captures a request, waits WAIT_CYCLES,
// then completes it with a one-cycle dReady pulse (plus dError on a bad access).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);

    localparam int                    AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int                    WAIT_LAST_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST   = WAIT_LAST_I[WAIT_CNT_W-1:0];
    localparam logic [31:0]           DEPTH_L     = 32'(DEPTH_WORDS);

    state_t                state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [AW-1:0]         idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  write_q, write_d;
    logic                  fail_q, fail_d;

    logic                  req;
    logic [31:0]           offset;
    logic [31:0]           word_idx;
    logic                  in_range;
    logic                  req_fail;
    logic                  ram_we;
    logic [31:0]           ram_rdata;

    // Address decode of the live request; only its value at capture matters.
    assign req      = bus.MemRead | bus.MemWrite;
    assign offset   = bus.dAddress - BASE_ADDR;
    assign word_idx = offset >> 2;
    assign in_range = (bus.dAddress >= BASE_ADDR) && (word_idx < DEPTH_L);
    assign req_fail = (bus.dAddress[1:0] != 2'b00)
                    | ~in_range
                    | (bus.MemRead & bus.MemWrite)
                    | (bus.MemWrite & ~bus.MemRead & (bus.dByteEn == 4'h0));

    // The write lands on the same edge that raises dReady; reset cancels it.
    assign ram_we = (state_q == DONE) & write_q & ~fail_q & ~rst;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (be_q),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        error_d = 1'b0;
        rdata_d = rdata_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        write_d = write_q;
        fail_d  = fail_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = word_idx[AW-1:0];
                    wdata_d = bus.dWriteData;
                    be_d    = bus.dByteEn;
                    write_d = bus.MemWrite;
                    fail_d  = req_fail;
                    cnt_d   = '0;
                    state_d = (WAIT_CYCLES > 0) ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Leaving DONE raises dReady; the FSM is back in IDLE for that cycle.
                ready_d = 1'b1;
                error_d = fail_q;
                state_d = IDLE;
                if (fail_q) begin
                    rdata_d = ZERO_WORD;
                end else if (!write_q) begin
                    rdata_d = ram_rdata;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            rdata_q <= ZERO_WORD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            error_q <= error_d;
            rdata_q <= rdata_d;
        end
    end

    // Captured request fields carry no reset; state alone decides their use.
    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        write_q <= write_d;
        fail_q  <= fail_d;
    end

    assign bus.dReady    = ready_q;
    assign bus.dError    = error_q;
    assign bus.dReadData = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table with a response scoreboard on a
// WAIT_CYCLES=2 instance, plus abort and back-to-back runs (WAIT_CYCLES=0).
module tb_dmem_responder;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
        logic        chk;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks      = 0;
    int   failures    = 0;
    int   ready_seen_a = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    dmem_if bus_a ();
    dmem_if bus_b ();

    dmem_responder #(
        .BASE_ADDR   (32'h1001_0000),
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (2)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    dmem_responder #(
        .BASE_ADDR   (32'h1001_0000),
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Response monitor for instance A: every dReady pops one expectation.
    always @(posedge clk) begin : mon_a
        exp_t e;
        #1;
        if (bus_a.dReady === 1'b1) begin
            ready_seen_a++;
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 32'(bus_a.dReady), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("resp_error", 32'(bus_a.dError), 32'(e.err));
                if (e.chk) check("resp_rdata", bus_a.dReadData, e.data);
            end
        end else begin
            check("error_without_ready", 32'(bus_a.dError), 32'd0);
        end
    end

    task automatic run_txn(input vec_t v, input int idx);
        exp_t e;
        int   lat;
        @(negedge clk);
        bus_a.MemRead    = v.rd;
        bus_a.MemWrite   = v.wr;
        bus_a.dAddress   = v.addr;
        bus_a.dWriteData = v.wdata;
        bus_a.dByteEn    = v.be;
        e.err  = v.err;
        e.chk  = v.chk;
        e.data = v.data;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        // Captured values must govern the rest of the transaction.
        bus_a.dAddress   = $urandom;
        bus_a.dWriteData = $urandom;
        bus_a.dByteEn    = 4'($urandom);
        lat = 0;
        while (bus_a.dReady !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("latency_v%0d", idx), 32'(lat), 32'd3);
        bus_a.MemRead  = 1'b0;
        bus_a.MemWrite = 1'b0;
        if (v.chk) begin
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("rdata_hold_v%0d", idx), bus_a.dReadData, v.data);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int   lat;
        int   base;
        int   pulses;
        int   consec;
        logic prev;

        //          rd    wr    addr           wdata          be       err   chk   data
        vecs.push_back('{1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF,    1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h1001_0004, 32'h0,         4'h0,    1'b0, 1'b1, 32'hDEAD_BEEF});
        vecs.push_back('{1'b0, 1'b1, 32'h1001_0004, 32'h0000_00AA, 4'b0001, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h1001_0004, 32'h0,         4'h0,    1'b0, 1'b1, 32'hDEAD_BEAA});
        vecs.push_back('{1'b1, 1'b0, 32'h1001_0002, 32'h0,         4'h0,    1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h1001_1000, 32'h0,         4'h0,    1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h1000_FFFC, 32'h0,         4'h0,    1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 32'h1001_0004, 32'h5555_5555, 4'hF,    1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h1001_0004, 32'h6666_6666, 4'h0,    1'b1, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h1001_0004, 32'h0,         4'h0,    1'b0, 1'b1, 32'hDEAD_BEAA});
        vecs.push_back('{1'b0, 1'b1, 32'h1001_0008, 32'h1234_5678, 4'hF,    1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h1001_0FFC, 32'h1122_3344, 4'hF,    1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h1001_0FFC, 32'h0,         4'h0,    1'b0, 1'b1, 32'h1122_3344});
        vecs.push_back('{1'b0, 1'b1, 32'h1001_0FFC, 32'hAABB_CCDD, 4'b1100, 1'b0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h1001_0FFC, 32'h0,         4'h0,    1'b0, 1'b1, 32'hAABB_3344});

        rst = 1'b1;
        bus_a.MemRead = 1'b0; bus_a.MemWrite = 1'b0; bus_a.dAddress = '0;
        bus_a.dWriteData = '0; bus_a.dByteEn = '0;
        bus_b.MemRead = 1'b0; bus_b.MemWrite = 1'b0; bus_b.dAddress = '0;
        bus_b.dWriteData = '0; bus_b.dByteEn = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready_a", 32'(bus_a.dReady), 32'd0);
        check("reset_error_a", 32'(bus_a.dError), 32'd0);
        check("reset_rdata_a", bus_a.dReadData, 32'd0);
        check("reset_ready_b", 32'(bus_b.dReady), 32'd0);
        check("reset_error_b", 32'(bus_b.dError), 32'd0);
        check("reset_rdata_b", bus_b.dReadData, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i], i);
        end

        // Reset while a write to 0x10010008 sits in WAIT: no completion, no write.
        @(negedge clk);
        bus_a.MemWrite   = 1'b1;
        bus_a.dAddress   = 32'h1001_0008;
        bus_a.dWriteData = 32'hCAFE_F00D;
        bus_a.dByteEn    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        rst            = 1'b1;
        bus_a.MemWrite = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        base = ready_seen_a;
        repeat (8) @(negedge clk);
        check("abort_no_ready", 32'(ready_seen_a - base), 32'd0);
        check("abort_rdata_cleared", bus_a.dReadData, 32'd0);
        run_txn('{1'b1, 1'b0, 32'h1001_0008, 32'h0, 4'h0, 1'b0, 1'b1, 32'h1234_5678}, 100);

        // Zero-wait instance: single write completes one edge after capture.
        @(negedge clk);
        bus_b.MemWrite   = 1'b1;
        bus_b.dAddress   = 32'h1001_0000;
        bus_b.dWriteData = 32'h0BAD_CAFE;
        bus_b.dByteEn    = 4'hF;
        @(posedge clk);
        #1;
        lat = 0;
        while (bus_b.dReady !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b_write_latency", 32'(lat), 32'd1);
        check("b_write_error", 32'(bus_b.dError), 32'd0);
        bus_b.MemWrite = 1'b0;

        // Read held high continuously: a pulse every second cycle, never adjacent.
        @(negedge clk);
        bus_b.MemRead = 1'b1;
        pulses = 0;
        consec = 0;
        prev   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus_b.dReady === 1'b1) begin
                pulses++;
                if (prev) consec++;
                check("b_stream_rdata", bus_b.dReadData, 32'h0BAD_CAFE);
                check("b_stream_error", 32'(bus_b.dError), 32'd0);
            end
            prev = bus_b.dReady;
        end
        bus_b.MemRead = 1'b0;
        check("b_stream_pulses", 32'(pulses), 32'd10);
        check("b_stream_adjacent", 32'(consec), 32'd0);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
